// File: rtl/log_offset_lut_pipe.sv
// Multi-channel pipelined log-offset lookup with a run-time writable table, a clear sweep,
// an out-of-range policy and valid/ready flow control on both the lookup and result sides.
module log_offset_lut_pipe #(
  parameter int unsigned       IDX_W   = 5,
  parameter int unsigned       OUT_W   = 40,
  parameter int unsigned       DEPTH   = 16,
  parameter int unsigned       NUM_CH  = 2,
  parameter bit                SAT     = 1'b0,
  parameter logic [OUT_W-1:0]  DEF_VAL = '0,
  localparam int unsigned      AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  input  logic                      cfg_op,
  input  logic [AW-1:0]             cfg_addr,
  input  logic [OUT_W-1:0]          cfg_data,
  output logic                      cfg_ready,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_CH*IDX_W-1:0]   shift_offset,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_CH*OUT_W-1:0]   log_offset
);

  typedef enum logic [0:0] {StRun, StClear} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          clr_cnt_q, clr_cnt_d;
  logic [OUT_W-1:0]       table_q [DEPTH];
  logic                   s1_valid_q;
  logic [IDX_W-1:0]       s1_idx_q [NUM_CH];
  logic [NUM_CH*OUT_W-1:0] lut_out;

  logic run, adv, clr_req, pipe_empty;
  logic cfg_wr_acc, clr_acc, in_acc;

  assign run        = (state_q == StRun);
  assign adv        = !out_valid || out_ready;
  assign clr_req    = cfg_valid && cfg_op;
  assign pipe_empty = !s1_valid_q && !out_valid;

  // A pending clear holds off new lookups so the pipe can drain before the sweep.
  assign cfg_ready  = run && (!cfg_op || pipe_empty);
  assign in_ready   = run && adv && !clr_req;

  assign cfg_wr_acc = cfg_valid && !cfg_op && cfg_ready;
  assign clr_acc    = clr_req && cfg_ready;
  assign in_acc     = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StRun: begin
        if (clr_acc) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Writes to addresses beyond the table are accepted and dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        table_q[i] <= '0;
      end
    end else if (state_q == StClear) begin
      table_q[clr_cnt_q] <= '0;
    end else if (cfg_wr_acc && (32'(cfg_addr) < DEPTH)) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  // Reads see the pre-edge table, so a same-cycle write is only visible on the next lookup.
  always_comb begin
    lut_out = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (32'(s1_idx_q[k]) < DEPTH) begin
        lut_out[k*OUT_W +: OUT_W] = table_q[s1_idx_q[k][AW-1:0]];
      end else if (SAT) begin
        lut_out[k*OUT_W +: OUT_W] = table_q[DEPTH-1];
      end else begin
        lut_out[k*OUT_W +: OUT_W] = DEF_VAL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
        s1_idx_q[k] <= '0;
      end
      out_valid  <= 1'b0;
      log_offset <= '0;
    end else if (adv) begin
      s1_valid_q <= in_acc;
      if (in_acc) begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
          s1_idx_q[k] <= shift_offset[k*IDX_W +: IDX_W];
        end
      end
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        log_offset <= lut_out;
      end
    end
  end

endmodule

// File: tb/tb_log_offset_lut_pipe.sv
// Directed bench for log_offset_lut_pipe: one instance with SAT=0 and a non-zero default,
// one with SAT=1, both driven by the same stimulus.
module tb_log_offset_lut_pipe;

  localparam logic [39:0] DEF = 40'hFC10001000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_op = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [39:0] cfg_data = '0;
  logic        in_valid = 1'b0;
  logic [9:0]  shift_offset = '0;
  logic        out_ready = 1'b1;

  logic        cfg_ready0, in_ready0, out_valid0;
  logic        cfg_ready1, in_ready1, out_valid1;
  logic [79:0] log_offset0, log_offset1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  log_offset_lut_pipe #(.SAT(1'b0), .DEF_VAL(DEF)) u_dut_def (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_op(cfg_op), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready0), .in_valid(in_valid), .in_ready(in_ready0),
    .shift_offset(shift_offset), .out_valid(out_valid0), .out_ready(out_ready),
    .log_offset(log_offset0)
  );

  log_offset_lut_pipe #(.SAT(1'b1)) u_dut_sat (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_op(cfg_op), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready1), .in_valid(in_valid), .in_ready(in_ready1),
    .shift_offset(shift_offset), .out_valid(out_valid1), .out_ready(out_ready),
    .log_offset(log_offset1)
  );

  function automatic logic [39:0] ev(input int i);
    return 40'hA500000000 | 40'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [39:0] data);
    cfg_valid = 1'b1;
    cfg_op    = 1'b0;
    cfg_addr  = 4'(addr);
    cfg_data  = data;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Presents one lookup with out_ready high, returns out_valid after one and two edges.
  task automatic do_lookup(input int l0, input int l1, output logic early, output logic v,
                           output logic [79:0] r0, output logic [79:0] r1);
    shift_offset = {5'(l1), 5'(l0)};
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    tick();
    in_valid = 1'b0;
    early    = out_valid0;
    tick();
    v  = out_valid0;
    r0 = log_offset0;
    r1 = log_offset1;
  endtask

  task automatic test_reset();
    logic e, v;
    logic [79:0] r0, r1;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (out_valid0 !== 1'b0 || log_offset0 !== 80'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b data=%h, need valid=0 data=0",
               out_valid0, log_offset0);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (in_ready0 !== 1'b1 || cfg_ready0 !== 1'b1 || in_ready1 !== 1'b1 || cfg_ready1 !== 1'b1)
    begin
      n_bad++;
      $display("FAIL reset_ready: got in_ready=%b cfg_ready=%b, need 1 1", in_ready0, cfg_ready0);
    end
    cfg_op = 1'b1;
    #1;
    n_cmp++;
    if (cfg_ready0 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_clear_ready: got %b need 1", cfg_ready0);
    end
    cfg_op = 1'b0;
    do_lookup(0, 15, e, v, r0, r1);
    n_cmp++;
    if (v !== 1'b1 || r0 !== 80'h0 || r1 !== 80'h0) begin
      n_bad++;
      $display("FAIL reset_table: got valid=%b %h %h, need valid=1 and zeros", v, r0, r1);
    end
  endtask

  task automatic test_write_lookup();
    logic e, v;
    logic [79:0] r0, r1;
    cfg_write(2, 40'h1A98A9800);
    cfg_write(3, 40'h3F44F4400);
    do_lookup(2, 3, e, v, r0, r1);
    n_cmp++;
    if (e !== 1'b0 || v !== 1'b1) begin
      n_bad++;
      $display("FAIL latency: got valid after 1 edge=%b, 2 edges=%b, need 0 then 1", e, v);
    end
    n_cmp++;
    if (r0 !== {40'h3F44F4400, 40'h1A98A9800} || r1 !== {40'h3F44F4400, 40'h1A98A9800}) begin
      n_bad++;
      $display("FAIL write_lookup: got %h / %h need %h", r0, r1,
               {40'h3F44F4400, 40'h1A98A9800});
    end
  endtask

  task automatic test_out_of_range();
    logic e, v;
    logic [79:0] r0, r1;
    do_lookup(20, 2, e, v, r0, r1);
    n_cmp++;
    if (r0 !== {40'h1A98A9800, DEF} || r1 !== {40'h1A98A9800, 40'h0}) begin
      n_bad++;
      $display("FAIL oor_default: got %h / %h need %h / %h", r0, r1,
               {40'h1A98A9800, DEF}, {40'h1A98A9800, 40'h0});
    end
    cfg_write(15, 40'hFF);
    do_lookup(20, 31, e, v, r0, r1);
    n_cmp++;
    if (r0 !== {DEF, DEF} || r1 !== {40'hFF, 40'hFF}) begin
      n_bad++;
      $display("FAIL oor_sat: got %h / %h need %h / %h", r0, r1, {DEF, DEF}, {40'hFF, 40'hFF});
    end
    do_lookup(15, 16, e, v, r0, r1);
    n_cmp++;
    if (r0 !== {DEF, 40'hFF} || r1 !== {40'hFF, 40'hFF}) begin
      n_bad++;
      $display("FAIL oor_edge: got %h / %h need %h / %h", r0, r1, {DEF, 40'hFF},
               {40'hFF, 40'hFF});
    end
  endtask

  task automatic test_back_to_back();
    int sent, recv;
    logic acc, stalled;
    logic [79:0] held;
    for (int i = 0; i < 16; i++) cfg_write(i, ev(i));
    sent    = 0;
    recv    = 0;
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      out_ready    = (c % 2 == 0);
      in_valid     = (sent < 8);
      shift_offset = {5'(15 - sent), 5'(sent)};
      #1;
      if (stalled) begin
        n_cmp++;
        if (out_valid0 !== 1'b1 || log_offset0 !== held) begin
          n_bad++;
          $display("FAIL stall_hold: got valid=%b %h need valid=1 %h", out_valid0,
                   log_offset0, held);
        end
      end
      if (out_valid0 && out_ready) begin
        n_cmp++;
        if (log_offset0 !== {ev(15 - recv), ev(recv)}) begin
          n_bad++;
          $display("FAIL stream_%0d: got %h need %h", recv, log_offset0,
                   {ev(15 - recv), ev(recv)});
        end
        recv++;
      end
      acc     = in_valid && in_ready0;
      stalled = out_valid0 && !out_ready;
      held    = log_offset0;
      tick();
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (sent != 8 || recv != 8) begin
      n_bad++;
      $display("FAIL stream_count: got sent=%0d recv=%0d need 8 8", sent, recv);
    end
    tick();
    tick();
    n_cmp++;
    if (out_valid0 !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_extra: got out_valid=%b need 0", out_valid0);
    end
  endtask

  task automatic test_collision();
    logic e, v;
    logic [79:0] r0, r1;
    shift_offset = {5'd5, 5'd5};
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    tick();
    in_valid  = 1'b0;
    cfg_valid = 1'b1;
    cfg_op    = 1'b0;
    cfg_addr  = 4'd5;
    cfg_data  = 40'h5;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (out_valid0 !== 1'b1 || log_offset0 !== {ev(5), ev(5)}) begin
      n_bad++;
      $display("FAIL collision_old: got valid=%b %h need valid=1 %h", out_valid0, log_offset0,
               {ev(5), ev(5)});
    end
    do_lookup(5, 5, e, v, r0, r1);
    n_cmp++;
    if (r0 !== {40'h5, 40'h5}) begin
      n_bad++;
      $display("FAIL collision_new: got %h need %h", r0, {40'h5, 40'h5});
    end
  endtask

  task automatic test_clear();
    int low, cfg_low, nres;
    logic acc, done;
    logic e, v;
    logic [79:0] res [2];
    logic [79:0] r0, r1;
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    shift_offset = {5'd5, 5'd0};
    tick();
    shift_offset = {5'd7, 5'd1};
    tick();
    in_valid  = 1'b0;
    cfg_valid = 1'b1;
    cfg_op    = 1'b1;
    low     = 0;
    cfg_low = 0;
    nres    = 0;
    done    = 1'b0;
    res[0]  = '0;
    res[1]  = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (out_valid0 && nres < 2) begin
        res[nres] = log_offset0;
        nres++;
      end
      if (in_ready0) break;
      low++;
      if (done && !cfg_ready0) cfg_low++;
      acc = cfg_valid && cfg_ready0;
      tick();
      if (acc) begin
        cfg_valid = 1'b0;
        cfg_op    = 1'b0;
        done      = 1'b1;
      end
    end
    cfg_valid = 1'b0;
    cfg_op    = 1'b0;
    n_cmp++;
    if (nres != 2 || res[0] !== {40'h5, ev(0)} || res[1] !== {ev(7), ev(1)}) begin
      n_bad++;
      $display("FAIL clear_inflight: got n=%0d %h %h need 2 %h %h", nres, res[0], res[1],
               {40'h5, ev(0)}, {ev(7), ev(1)});
    end
    n_cmp++;
    if (low != 19) begin
      n_bad++;
      $display("FAIL clear_in_ready_low: got %0d cycles need 19", low);
    end
    n_cmp++;
    if (cfg_low != 16) begin
      n_bad++;
      $display("FAIL clear_cfg_ready_low: got %0d cycles need 16", cfg_low);
    end
    for (int i = 0; i < 8; i++) begin
      do_lookup(i, i + 8, e, v, r0, r1);
      n_cmp++;
      if (v !== 1'b1 || r0 !== 80'h0 || r1 !== 80'h0) begin
        n_bad++;
        $display("FAIL clear_zero_%0d: got valid=%b %h %h need 1 and zeros", i, v, r0, r1);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic e, v;
    logic [79:0] r0, r1;
    cfg_write(12, 40'h1234);
    cfg_write(15, 40'h77);
    cfg_valid = 1'b1;
    cfg_op    = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_op    = 1'b0;
    repeat (7) tick();
    n_cmp++;
    if (in_ready0 !== 1'b0) begin
      n_bad++;
      $display("FAIL midclear_busy: got in_ready=%b need 0", in_ready0);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid0 !== 1'b0 || log_offset0 !== 80'h0 || in_ready0 !== 1'b1) begin
      n_bad++;
      $display("FAIL midclear_rst: got valid=%b data=%h in_ready=%b need 0 0 1", out_valid0,
               log_offset0, in_ready0);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (in_ready0 !== 1'b1 || cfg_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      n_bad++;
      $display("FAIL midclear_ready: got in_ready=%b cfg_ready=%b need 1 1", in_ready0,
               cfg_ready0);
    end
    do_lookup(12, 15, e, v, r0, r1);
    n_cmp++;
    if (r0 !== 80'h0 || out_valid1 !== 1'b1) begin
      n_bad++;
      $display("FAIL midclear_table: got %h need 0", r0);
    end
    do_lookup(20, 20, e, v, r0, r1);
    n_cmp++;
    if (r1 !== 80'h0 || r0 !== {DEF, DEF}) begin
      n_bad++;
      $display("FAIL midclear_sat: got %h / %h need 0 / %h", r1, r0, {DEF, DEF});
    end
  endtask

  initial begin
    test_reset();
    test_write_lookup();
    test_out_of_range();
    test_back_to_back();
    test_collision();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
